mu0_cpu_stallable: RTL and testbench
====================================

// Module: mu0_cpu_stallable
// PURPOSE
//  Parametrised MU0 accumulator CPU with an internal fetch/execute FSM and a stall-capable memory bus.
//  Drives one shared instruction/data memory port with read/write/waitrequest and a fixed 1-cycle read latency.
//  Adds LDI, signed JGE, a halted flag, an illegal-opcode trap and an OUT stream port.
//  Sits between the testbench/top level and the unified memory model.
// PARAMETERS
//  ADDR_WIDTH  12  address/PC width; instruction = {opcode[3:0], constant[ADDR_WIDTH-1:0]}
//  DATA_WIDTH  16  derived, fixed = ADDR_WIDTH+4; acc/bus data width (localparam, not overridable)
//  RESET_PC    0   PC value loaded on reset
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst          in   1           synchronous, active-high reset
//  address      out  ADDR_WIDTH  memory address
//  read         out  1           read command
//  write        out  1           write command
//  writedata    out  DATA_WIDTH  store data (= acc)
//  readdata     in   DATA_WIDTH  valid the cycle after an accepted read
//  waitrequest  in   1           high = command not accepted; hold address/read/write/writedata
//  out_valid    out  1           one-cycle pulse per OUT instruction
//  out_data     out  DATA_WIDTH  acc value at the OUT; valid with out_valid
//  halted       out  1           high in HALTED
//  illegal      out  1           high when halted by an undefined opcode
//  state        out  3           FSM state, debug
// BEHAVIOUR
//  Reset: state=FETCH_ADDR, pc=RESET_PC, acc=0, instr=0.
//   Outputs: read=write=0 during the rst cycle; out_valid=halted=illegal=0.
//   rst overrides everything, including mid-access or while HALTED.
//   An outstanding read is abandoned; its readdata is ignored.
//  Opcodes:
//   LDA=0, STO=1, ADD=2, SUB=3, JMP=4, JGE=5, JNE=6, STP=7, OUT=8, LDI=9; 10..15 illegal.
//  States: FETCH_ADDR=0, FETCH_DATA=1, EXEC_ADDR=2, EXEC_DATA=3, HALTED=4.
//  FETCH_ADDR: read=1, address=pc. waitrequest=1 -> stay, outputs stable; else -> FETCH_DATA.
//  FETCH_DATA: instr<=readdata, read=0 -> EXEC_ADDR.
//  EXEC_ADDR, decode of instr:
//   LDA/ADD/SUB: read=1, address=constant; accepted (waitrequest=0) -> EXEC_DATA, else hold.
//   STO: write=1, address=constant, writedata=acc; accepted -> pc<=pc+1, FETCH_ADDR.
//   JMP: pc<=constant.
//   JGE: pc<=constant if $signed(acc)>=0, else pc+1.
//   JNE: pc<=constant if acc!=0, else pc+1.
//   LDI: acc<=zero-extended constant, pc+1.
//   OUT: out_valid=1, out_data=acc (registered, asserted the next cycle for exactly 1 cycle), pc+1.
//   JMP/JGE/JNE/LDI/OUT: no bus access, -> FETCH_ADDR.
//   STP: -> HALTED, pc unchanged.
//   Illegal: -> HALTED, illegal<=1, pc unchanged.
//  EXEC_DATA: LDA acc<=readdata; ADD acc<=acc+readdata; SUB acc<=acc-readdata. Then pc+1 -> FETCH_ADDR.
//  Arithmetic: modulo 2^DATA_WIDTH, no flags. pc+1 wraps modulo 2^ADDR_WIDTH (max address -> 0).
//  read and write are never both high. waitrequest is ignored when no command is asserted.
//  HALTED: no bus activity, halted=1, holds until rst.
//  Cycle counts with waitrequest=0:
//   LDA/ADD/SUB = 4 cycles.
//   STO/JMP/JGE/JNE/LDI/OUT = 3 cycles.
//   Each waitrequest-high cycle adds 1.
// TESTING
//  1. mem[0]=LDI 5, mem[1]=ADD 0x20, mem[2]=OUT, mem[3]=STP, mem[0x20]=7
//     -> out_data=12 with one out_valid pulse; halted=1; pc=3.
//  2. Same program, waitrequest high for 3 cycles on every command
//     -> identical results; address/read stable while stalled; +3 cycles per access.
//  3. acc=0x8000, JGE 0x10 -> pc=next (negative); acc=0, JGE 0x10 -> pc=0x10; acc=0, JNE -> falls through.
//  4. STO 0x30 with acc=0xBEEF -> exactly one accepted write: address=0x30, writedata=0xBEEF.
//  5. Opcode 0xA at pc=4 -> halted=1, illegal=1, no further read/write.
//     Then rst for 1 cycle -> pc=0, flags clear, fetch from 0 restarts.
//  6. ADDR_WIDTH=8: JMP 0xFF, then LDI -> pc wraps 0xFF -> 0x00.
//     Plus rst asserted mid-EXEC_DATA -> acc=0 with no acc update.

Source files
------------

// File: rtl/mu0_cpu_stallable.sv
// MU0 accumulator CPU: fetch/execute FSM on a single shared memory port with
// waitrequest stalls, 1-cycle read latency, LDI/JGE/OUT extensions and halt/illegal traps.
module mu0_cpu_stallable #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  output logic                  write,
  output logic [ADDR_WIDTH+3:0] writedata,
  input  logic [ADDR_WIDTH+3:0] readdata,
  input  logic                  waitrequest,
  output logic                  out_valid,
  output logic [ADDR_WIDTH+3:0] out_data,
  output logic                  halted,
  output logic                  illegal,
  output logic [2:0]            state
);
  localparam int unsigned DATA_WIDTH = ADDR_WIDTH + 4;

  typedef enum logic [2:0] {
    FETCH_ADDR = 3'd0,
    FETCH_DATA = 3'd1,
    EXEC_ADDR  = 3'd2,
    EXEC_DATA  = 3'd3,
    HALTED     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    OP_LDA = 4'd0, OP_STO = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_JMP = 4'd4,
    OP_JGE = 4'd5, OP_JNE = 4'd6, OP_STP = 4'd7, OP_OUT = 4'd8, OP_LDI = 4'd9
  } op_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc, konst, addr_c;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, instr_q, instr_d, out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d, illegal_q, illegal_d;
  logic                  read_c, write_c;
  logic [3:0]            opcode;

  assign opcode = instr_q[DATA_WIDTH-1 -: 4];
  assign konst  = instr_q[ADDR_WIDTH-1:0];
  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    instr_d     = instr_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    read_c      = 1'b0;
    write_c     = 1'b0;
    addr_c      = pc_q;
    case (state_q)
      FETCH_ADDR: begin
        read_c = 1'b1;
        if (!waitrequest) state_d = FETCH_DATA;
      end
      FETCH_DATA: begin
        instr_d = readdata;
        state_d = EXEC_ADDR;
      end
      EXEC_ADDR: begin
        addr_c = konst;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            read_c = 1'b1;
            if (!waitrequest) state_d = EXEC_DATA;
          end
          OP_STO: begin
            write_c = 1'b1;
            if (!waitrequest) begin
              pc_d    = pc_inc;
              state_d = FETCH_ADDR;
            end
          end
          OP_JMP: begin
            pc_d    = konst;
            state_d = FETCH_ADDR;
          end
          OP_JGE: begin
            pc_d    = acc_q[DATA_WIDTH-1] ? pc_inc : konst;
            state_d = FETCH_ADDR;
          end
          OP_JNE: begin
            pc_d    = (acc_q != '0) ? konst : pc_inc;
            state_d = FETCH_ADDR;
          end
          OP_LDI: begin
            acc_d   = {4'b0000, konst};
            pc_d    = pc_inc;
            state_d = FETCH_ADDR;
          end
          OP_OUT: begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
            pc_d        = pc_inc;
            state_d     = FETCH_ADDR;
          end
          OP_STP: state_d = HALTED;
          default: begin
            illegal_d = 1'b1;
            state_d   = HALTED;
          end
        endcase
      end
      EXEC_DATA: begin
        case (opcode)
          OP_LDA:  acc_d = readdata;
          OP_ADD:  acc_d = acc_q + readdata;
          OP_SUB:  acc_d = acc_q - readdata;
          default: acc_d = acc_q;
        endcase
        pc_d    = pc_inc;
        state_d = FETCH_ADDR;
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_ADDR;
      pc_q        <= RESET_PC;
      acc_q       <= '0;
      instr_q     <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      instr_q     <= instr_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Commands are combinational from state, so gate them off while rst is high.
  assign read      = read_c & ~rst;
  assign write     = write_c & ~rst;
  assign address   = addr_c;
  assign writedata = acc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign halted    = (state_q == HALTED);
  assign illegal   = illegal_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mu0_cpu_stallable.sv
// Bench for mu0_cpu_stallable: unified memory with programmable stalls, an
// instruction-level reference interpreter, directed and random programs.
module tb_mu0_cpu_stallable;
  localparam int unsigned BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [11:0] address;
  logic        read, write, waitrequest, out_valid, halted, illegal;
  logic [15:0] writedata, readdata, out_data;
  logic [2:0]  state;

  logic [7:0]  address8;
  logic        read8, write8, out_valid8, halted8, illegal8;
  logic        waitrequest8;
  logic [11:0] writedata8, readdata8, out_data8;
  logic [2:0]  state8;

  logic [15:0] img  [0:4095];
  logic [15:0] mem  [0:4095];
  logic [11:0] img8 [0:255];
  logic [11:0] mem8 [0:255];
  int unsigned stall_n = 0;
  int unsigned wait_cnt = 0;

  logic [15:0] exp_outs[$], obs_outs[$];
  logic [27:0] exp_wr[$], obs_wr[$];
  int unsigned exp_cycles, obs_cycles;
  logic [11:0] exp_halt_pc, obs_halt_pc;
  logic        exp_illegal;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mu0_cpu_stallable dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .out_valid(out_valid), .out_data(out_data), .halted(halted),
    .illegal(illegal), .state(state)
  );

  mu0_cpu_stallable #(.ADDR_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .address(address8), .read(read8), .write(write8),
    .writedata(writedata8), .readdata(readdata8), .waitrequest(waitrequest8),
    .out_valid(out_valid8), .out_data(out_data8), .halted(halted8),
    .illegal(illegal8), .state(state8)
  );

  // waitrequest is also high while idle when stalls are enabled; the CPU must ignore it.
  assign waitrequest  = (wait_cnt < stall_n);
  assign waitrequest8 = 1'b0;

  always @(posedge clk) begin
    if (rst) wait_cnt <= 0;
    else if (read || write) wait_cnt <= waitrequest ? wait_cnt + 1 : 0;
    if (load_en) mem <= img;
    else if (write && !waitrequest) mem[address] <= writedata;
    if (read && !waitrequest) readdata <= mem[address];
  end

  always @(posedge clk) begin
    if (load_en) mem8 <= img8;
    else if (write8) mem8[address8] <= writedata8;
    if (read8) readdata8 <= mem8[address8];
  end

  task automatic clear_img();
    for (int i = 0; i < 4096; i++) img[i] = 16'h0000;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; load_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; load_en = 1'b0;
    #1;
  endtask

  task automatic ref_run(input int unsigned sn);
    logic [15:0] m [0:4095];
    logic [11:0] pc, k;
    logic [15:0] acc, ins;
    logic [3:0]  op;
    bit          done;
    m = img; pc = 12'h000; acc = 16'h0000; done = 1'b0;
    exp_outs.delete(); exp_wr.delete();
    exp_cycles = 0; exp_illegal = 1'b0; exp_halt_pc = 12'h000;
    for (int n = 0; n < 4000; n++) begin
      ins = m[pc]; op = ins[15:12]; k = ins[11:0];
      exp_cycles += 3 + sn;
      case (op)
        4'd0: begin acc = m[k];       exp_cycles += 1 + sn; pc = pc + 12'd1; end
        4'd1: begin m[k] = acc; exp_wr.push_back({k, acc}); exp_cycles += sn; pc = pc + 12'd1; end
        4'd2: begin acc = acc + m[k]; exp_cycles += 1 + sn; pc = pc + 12'd1; end
        4'd3: begin acc = acc - m[k]; exp_cycles += 1 + sn; pc = pc + 12'd1; end
        4'd4: pc = k;
        4'd5: pc = ($signed(acc) >= 0) ? k : pc + 12'd1;
        4'd6: pc = (acc != 16'h0000) ? k : pc + 12'd1;
        4'd7: begin exp_halt_pc = pc; done = 1'b1; end
        4'd8: begin exp_outs.push_back(acc); pc = pc + 12'd1; end
        4'd9: begin acc = {4'h0, k}; pc = pc + 12'd1; end
        default: begin exp_halt_pc = pc; exp_illegal = 1'b1; done = 1'b1; end
      endcase
      if (done) break;
    end
  endtask

  // Loads img, resets the CPU, runs until HALTED and compares against ref_run.
  task automatic run_prog(input string name, input int unsigned sn);
    bit          prev_stall = 1'b0;
    logic        prev_r = 1'b0, prev_w = 1'b0;
    logic [11:0] prev_a = '0;
    logic [15:0] prev_d = '0;
    int unsigned both_cmd = 0, unstable = 0, idle_bus = 0;
    ref_run(sn);
    stall_n = sn;
    obs_outs.delete(); obs_wr.delete();
    obs_cycles = 0; obs_halt_pc = 12'hFFF;
    apply_reset();
    while (!halted && obs_cycles < BUDGET) begin
      if (read && write) both_cmd++;
      if (prev_stall && (read !== prev_r || write !== prev_w || address !== prev_a ||
                         (write && writedata !== prev_d))) unstable++;
      prev_stall = (read || write) && waitrequest;
      prev_r = read; prev_w = write; prev_a = address; prev_d = writedata;
      if (out_valid) obs_outs.push_back(out_data);
      if (write && !waitrequest) obs_wr.push_back({address, writedata});
      if (state == 3'd0 && read && !waitrequest) obs_halt_pc = address;
      obs_cycles++;
      @(negedge clk);
    end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL %s halt: halted=%b after %0d cycles, required 1", name, halted, obs_cycles); end
    checks++;
    if (obs_cycles !== exp_cycles) begin errors++; $display("FAIL %s cycles: got %0d required %0d", name, obs_cycles, exp_cycles); end
    checks++;
    if (obs_halt_pc !== exp_halt_pc) begin errors++; $display("FAIL %s halt_pc: got %h required %h", name, obs_halt_pc, exp_halt_pc); end
    checks++;
    if (illegal !== exp_illegal) begin errors++; $display("FAIL %s illegal: got %b required %b", name, illegal, exp_illegal); end
    checks++;
    if (obs_outs.size() !== exp_outs.size()) begin errors++; $display("FAIL %s out_count: got %0d required %0d", name, obs_outs.size(), exp_outs.size()); end
    for (int i = 0; i < obs_outs.size() && i < exp_outs.size(); i++) begin
      checks++;
      if (obs_outs[i] !== exp_outs[i]) begin errors++; $display("FAIL %s out_data[%0d]: got %h required %h", name, i, obs_outs[i], exp_outs[i]); end
    end
    checks++;
    if (obs_wr.size() !== exp_wr.size()) begin errors++; $display("FAIL %s write_count: got %0d required %0d", name, obs_wr.size(), exp_wr.size()); end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL %s write[%0d] {addr,data}: got %h required %h", name, i, obs_wr[i], exp_wr[i]); end
    end
    for (int c = 0; c < 4; c++) begin
      if (read || write || !halted) idle_bus++;
      @(negedge clk);
    end
    checks++;
    if (idle_bus !== 0) begin errors++; $display("FAIL %s halted_idle: %0d active/unhalted cycles, required 0", name, idle_bus); end
    checks++;
    if (both_cmd !== 0) begin errors++; $display("FAIL %s read_and_write: %0d cycles, required 0", name, both_cmd); end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL %s stall_stability: %0d changes, required 0", name, unstable); end
  endtask

  task automatic load_basic();
    clear_img();
    img[0] = 16'h9005; img[1] = 16'h2020; img[2] = 16'h8000; img[3] = 16'h7000;
    img[12'h020] = 16'h0007;
  endtask

  task automatic test_basic();
    load_basic();
    run_prog("basic", 0);
    checks++;
    if (obs_outs.size() < 1 || obs_outs[0] !== 16'd12) begin errors++; $display("FAIL basic_out12: got %0d values, required first value 12", obs_outs.size()); end
    checks++;
    if (obs_cycles !== 13) begin errors++; $display("FAIL basic_cycles_const: got %0d required 13", obs_cycles); end
  endtask

  task automatic test_stall();
    load_basic();
    run_prog("stall3", 3);
    checks++;
    if (obs_cycles !== 28) begin errors++; $display("FAIL stall3_cycles_const: got %0d required 28", obs_cycles); end
  endtask

  task automatic test_jumps();
    clear_img();
    img[0] = 16'h0040; img[1] = 16'h5010; img[2] = 16'h8000; img[3] = 16'h7000;
    img[12'h010] = 16'h9007; img[12'h011] = 16'h8000; img[12'h012] = 16'h7000;
    img[12'h040] = 16'h8000;
    run_prog("jge_negative", 0);
    img[0] = 16'h9000;
    run_prog("jge_zero", 1);
    img[1] = 16'h6010;
    run_prog("jne_zero", 0);
  endtask

  task automatic test_store();
    clear_img();
    img[0] = 16'h0040; img[1] = 16'h1030; img[2] = 16'h7000;
    img[12'h040] = 16'hBEEF;
    run_prog("store", 2);
    checks++;
    if (obs_wr.size() !== 1 || obs_wr[0] !== {12'h030, 16'hBEEF}) begin errors++; $display("FAIL store_const: %0d writes, required one write 030/BEEF", obs_wr.size()); end
  endtask

  task automatic test_illegal();
    clear_img();
    img[0] = 16'h9001; img[1] = 16'h9002; img[2] = 16'h9003; img[3] = 16'h9004; img[4] = 16'hA000;
    run_prog("illegal", 0);
  endtask

  // Reset out of HALTED/illegal: commands gated during rst, state cleared, fetch restarts at 0.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (read !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL reset_cmd_gate: read=%b write=%b required 0 0", read, write); end
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state); end
    checks++;
    if (halted !== 1'b0 || illegal !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_flags: halted=%b illegal=%b out_valid=%b required 0 0 0", halted, illegal, out_valid); end
    rst = 1'b0;
    #1;
    checks++;
    if (read !== 1'b1 || address !== 12'h000) begin errors++; $display("FAIL reset_refetch: read=%b address=%h required 1 000", read, address); end
  endtask

  task automatic test_reset_mid_exec();
    int c;
    clear_img();
    img[0] = 16'h9005; img[1] = 16'h0020; img[2] = 16'h8000; img[3] = 16'h7000;
    img[12'h020] = 16'h1234;
    stall_n = 0;
    apply_reset();
    c = 0;
    while (state !== 3'd3 && c < 40) begin @(negedge clk); c++; end
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL mid_reset_reach: state=%0d required 3", state); end
    clear_img();
    img[0] = 16'h8000; img[1] = 16'h7000;
    rst = 1'b1; load_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; load_en = 1'b0;
    #1;
    c = 0;
    while (!out_valid && c < 20) begin @(negedge clk); c++; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000) begin errors++; $display("FAIL mid_reset_acc: out_valid=%b out_data=%h required 1 0000", out_valid, out_data); end
  endtask

  task automatic test_wrap8();
    logic [7:0] fa [3];
    int nf = 0;
    apply_reset();
    for (int c = 0; c < 15 && nf < 3; c++) begin
      if (state8 == 3'd0 && read8) begin fa[nf] = address8; nf++; end
      @(negedge clk);
    end
    checks++;
    if (nf !== 3) begin errors++; $display("FAIL wrap8_fetches: got %0d required 3", nf); end
    else begin
      checks++;
      if (fa[0] !== 8'h00 || fa[1] !== 8'hFF || fa[2] !== 8'h00) begin errors++; $display("FAIL wrap8_pc: got %h %h %h required 00 FF 00", fa[0], fa[1], fa[2]); end
    end
  endtask

  // Straight-line programs with forward-only branches so every run halts.
  task automatic test_random();
    int unsigned n, r, sn;
    logic [11:0] k;
    logic [3:0]  op;
    for (int p = 0; p < 10; p++) begin
      clear_img();
      for (int a = 12'h100; a < 12'h110; a++) img[a] = 16'($urandom);
      n = $urandom_range(8, 24);
      for (int unsigned i = 0; i + 1 < n; i++) begin
        r = $urandom_range(0, 9);
        k = 12'(12'h100 + $urandom_range(0, 15));
        case (r)
          0: op = 4'd0; 1: op = 4'd2; 2: op = 4'd3; 3: op = 4'd1;
          4: begin op = 4'd9; k = 12'($urandom); end
          6: begin op = 4'd4; k = 12'($urandom_range(i + 1, n - 1)); end
          7: begin op = 4'd5; k = 12'($urandom_range(i + 1, n - 1)); end
          8: begin op = 4'd6; k = 12'($urandom_range(i + 1, n - 1)); end
          default: op = 4'd8;
        endcase
        if ($urandom_range(0, 40) == 0) op = 4'($urandom_range(10, 15));
        img[i] = {op, k};
      end
      img[n - 1] = 16'h7000;
      sn = $urandom_range(0, 3);
      run_prog($sformatf("random%0d", p), sn);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img8[i] = 12'h000;
    img8[8'h00] = 12'h4FF;
    img8[8'hFF] = 12'h912;
    clear_img();
    test_basic();
    test_stall();
    test_jumps();
    test_store();
    test_illegal();
    test_reset();
    test_reset_mid_exec();
    test_wrap8();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
